rec2pol_seq: RTL
================

# rec2pol_seq

Sequencer and quadrant-extension front/back end for the CORDIC vectoring core `rec2pol`. It accepts rectangular samples (16Q16) over a valid/ready handshake and folds left-half-plane inputs into the core's legal range. It drives the core's `start`/`enable` protocol and counts the iterations. It then corrects and rescales the core's angle to a full ±180° result and holds the polar result in an output register with its own valid/ready handshake, so the next conversion can start while a result is still waiting.

## Interface

**Parameters**
- `NITER`, default 32: number of CORDIC iterations the core runs per conversion, range 1..63.

**Ports**
- `clock` (in, 1): clock. Everything is rising-edge.
- `reset` (in, 1): reset, asynchronous, active-high.
- `in_valid` (in, 1): an input sample is present.
- `in_ready` (out, 1): the block accepts a sample this cycle.
- `in_x`, `in_y` (in, 32, signed): rectangular coordinates, 16Q16.
- `out_valid` (out, 1): the output register holds a result.
- `out_ready` (in, 1): the consumer takes the result this cycle.
- `out_mod` (out, 32, signed): modulus, 16Q16, passed through from the core.
- `out_angle` (out, 32, signed): angle in degrees, 9Q23, range (−180, +180].
- `busy` (out, 1): the state is not IDLE.
- `core_start` (out, 1): to core `start`.
- `core_enable` (out, 1): to core `enable`.
- `core_x`, `core_y` (out, 32, signed): to core `x`/`y`, 16Q16.
- `core_mod` (in, 32, signed): from core `mod`.
- `core_angle` (in, 32, signed): from core `angle`, 8Q24.

## Operation

**Reset values**
- State is IDLE, the iteration counter is 0 and the `neg` flag is 0.
- `in_ready`=1, `out_valid`=0, `busy`=0, `core_start`=0, `core_enable`=0.
- `core_x`, `core_y`, `out_mod` and `out_angle` are all 0.

**State machine: IDLE → LOAD → RUN → HOLD → IDLE**
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, register the operands and go to LOAD.
  - If `in_x` < 0: `core_x`=sat(−`in_x`), `core_y`=sat(−`in_y`), `neg`=1, and register `ysgn` = (`in_y` < 0). Otherwise pass the operands through and set `neg`=0.
  - sat(−v) maps 0x80000000 to 0x7FFFFFFF.
- **LOAD** (1 cycle)
  - `core_start`=1, `core_enable`=1.
  - Clear the counter and go to RUN.
- **RUN**
  - `core_enable`=1 and the counter increments each cycle.
  - When the counter reaches `NITER`−1, go to HOLD.
- **HOLD**
  - `core_enable`=0; the core must hold its state while `enable` is 0.
  - If `out_valid`=0 or `out_ready`=1, capture the result and go to IDLE. Otherwise stay in HOLD.

**Angle correction at capture**
- a = `core_angle` >>> 1, arithmetic shift, giving 9Q23.
- If `neg`=0: `out_angle` = a.
- If `neg`=1 and `ysgn`=0: `out_angle` = a + 1509949440 (this is +180·2²³).
- If `neg`=1 and `ysgn`=1: `out_angle` = a − 1509949440.
- `out_mod` = `core_mod`, unchanged.
- `in_x`=0 is treated as non-negative.

**Output handshake**
- `out_valid` clears on `out_ready` when no capture happens in the same cycle.
- A capture and a pop in the same cycle leave `out_valid`=1 with the new data.
- `out_mod` and `out_angle` are stable while `out_valid`=1 and `out_ready`=0.

## Timing

- Let E0 be the edge at which the sample is accepted. `core_start` is high in the cycle after E0.
- RUN lasts exactly `NITER` cycles.
- With no backpressure, `out_valid` rises NITER+2 cycles after E0 (34 for the default).
- `in_ready` is low from E0 until the block returns to IDLE, so the minimum issue interval is NITER+3 cycles.
- Backpressure extends HOLD indefinitely. The core is frozen (`enable`=0) during HOLD.
- Reset asserted mid-conversion drops the result, clears `out_valid`, and returns everything to its reset values on the next cycle.
- `core_x` and `core_y` are stable from LOAD through the end of HOLD.

## Test plan

Angle tolerance for the scenarios below is ±512 LSB; modulus tolerance is ±4 LSB.

- **Quadrant I.** (x,y)=(3.0,4.0) → `out_mod`=327680 (5.0); `out_angle`≈445687598 (53.130°); `out_valid` at E0+34.
- **Quadrant II.** (−3.0,4.0) → `core_x`=196608, `core_y`=−262144; `out_mod`=327680; `out_angle`≈1064261840 (126.870°).
- **Negative real axis and quadrant III.**
  - (−1.0,0) → `out_mod`=65536, `out_angle`≈1509949440 (+180°).
  - (−1.0,−1.0) → `out_mod`≈92682, `out_angle`≈−1132462080 (−135°).
- **Backpressure.** Hold `out_ready`=0 and send two samples back to back.
  - The first result is held stable.
  - The second conversion reaches HOLD with `core_enable`=0 and `in_ready`=0.
  - Raise `out_ready` for one cycle: the first result pops, the second is captured on the same edge, and `out_valid` stays 1.
- **Reset mid-run.** Assert `reset` during RUN → `out_valid`, `busy`, `core_start` and `core_enable` all read 0 and `in_ready`=1 immediately. A fresh (3.0,4.0) after reset completes normally.
- **Saturation.** (0x80000000, 0x80000000) → `core_x`=`core_y`=0x7FFFFFFF and `neg`=1; the angle result is ≈−135°.

Source files
------------

// File: rtl/rec2pol_seq.sv
// Sequencer around the rec2pol CORDIC vectoring core: folds left-half-plane
// inputs, runs the core for NITER iterations and extends the angle to +/-180 deg.
//
// state | meaning
// IDLE  | waiting for an input sample, in_ready high
// LOAD  | core_start pulse, operands presented to the core
// RUN   | core iterating, NITER cycles
// HOLD  | core frozen, waiting for room in the output register
module rec2pol_seq #(
   parameter int unsigned NITER = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [31:0] in_x,
   input  logic signed [31:0] in_y,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [31:0] out_mod,
   output logic signed [31:0] out_angle,
   output logic               busy,
   output logic               core_start,
   output logic               core_enable,
   output logic signed [31:0] core_x,
   output logic signed [31:0] core_y,
   input  logic signed [31:0] core_mod,
   input  logic signed [31:0] core_angle
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD} state_t;

   localparam logic [5:0]         CNT_LAST = 6'(NITER - 1);
   localparam logic signed [31:0] DEG180   = 32'sd1509949440;

   state_t             state_q;
   logic [5:0]         cnt_q;
   logic               neg_q;
   logic               ysgn_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               busy_q;
   logic               core_start_q;
   logic               core_enable_q;
   logic signed [31:0] core_x_q;
   logic signed [31:0] core_y_q;
   logic signed [31:0] out_mod_q;
   logic signed [31:0] out_angle_q;

   logic               x_neg;
   logic signed [31:0] core_x_d;
   logic signed [31:0] core_y_d;
   logic signed [31:0] half_angle;
   logic signed [31:0] out_angle_d;
   logic               capture;
   logic               unused_angle_lsb;

   // Negation that cannot overflow: the most negative value maps to the most positive.
   function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v);
      return (v == 32'sh8000_0000) ? 32'sh7FFF_FFFF : -v;
   endfunction

   always_comb begin
      x_neg      = in_x[31];
      core_x_d   = x_neg ? sat_neg(in_x) : in_x;
      core_y_d   = x_neg ? sat_neg(in_y) : in_y;
      half_angle = core_angle >>> 1;
      if (!neg_q)
         out_angle_d = half_angle;
      else if (ysgn_q)
         out_angle_d = half_angle - DEG180;
      else
         out_angle_d = half_angle + DEG180;
      capture = (state_q == S_HOLD) && (!out_valid_q || out_ready);
   end

   assign unused_angle_lsb = core_angle[0];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         neg_q         <= 1'b0;
         ysgn_q        <= 1'b0;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         core_start_q  <= 1'b0;
         core_enable_q <= 1'b0;
         core_x_q      <= '0;
         core_y_q      <= '0;
         out_mod_q     <= '0;
         out_angle_q   <= '0;
      end else begin
         // A pop frees the output register; a capture on the same edge overrides it.
         if (out_ready)
            out_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  core_x_q      <= core_x_d;
                  core_y_q      <= core_y_d;
                  neg_q         <= x_neg;
                  ysgn_q        <= in_y[31];
                  in_ready_q    <= 1'b0;
                  busy_q        <= 1'b1;
                  core_start_q  <= 1'b1;
                  core_enable_q <= 1'b1;
                  state_q       <= S_LOAD;
               end
            end
            S_LOAD: begin
               core_start_q <= 1'b0;
               cnt_q        <= '0;
               state_q      <= S_RUN;
            end
            S_RUN: begin
               if (cnt_q == CNT_LAST) begin
                  core_enable_q <= 1'b0;
                  state_q       <= S_HOLD;
               end else begin
                  cnt_q <= cnt_q + 6'd1;
               end
            end
            S_HOLD: begin
               if (capture) begin
                  out_mod_q   <= core_mod;
                  out_angle_q <= out_angle_d;
                  out_valid_q <= 1'b1;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_mod     = out_mod_q;
   assign out_angle   = out_angle_q;
   assign busy        = busy_q;
   assign core_start  = core_start_q;
   assign core_enable = core_enable_q;
   assign core_x      = core_x_q;
   assign core_y      = core_y_q;

endmodule
